// File: rtl/grain.sv
// Grain-style keystream generator: 80-bit LFSR coupled to a 24-bit NLFSR,
// with a nonlinear filter producing one keystream bit from the current state.
module grain (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         Par_load,
  input  logic [104:0] Seed,
  output logic         out,
  output logic [79:0]  out_l,
  output logic [23:0]  out_n
);

  logic [79:0] l_q;
  logic [23:0] n_q;
  logic        fb_l;
  logic        fb_n;
  logic        h;

  // Seed[104] carries no meaning; tapped here only so the port bit is referenced.
  logic        unused_seed_msb;
  assign unused_seed_msb = Seed[104];

  // LFSR feedback, taken from the pre-step state.
  always_comb begin
    fb_l = l_q[0] ^ l_q[13] ^ l_q[23] ^ l_q[38] ^ l_q[51] ^ l_q[62];
  end

  // NLFSR feedback: linear taps, LFSR coupling via L[0], and nonlinear terms.
  always_comb begin
    fb_n = l_q[0] ^ n_q[0] ^ n_q[5] ^ n_q[9] ^ n_q[14] ^ n_q[20]
         ^ (n_q[3] & n_q[7])
         ^ (n_q[11] & n_q[17])
         ^ (n_q[2] & n_q[19] & n_q[22]);
  end

  // Output filter: nonlinear h combined with linear NLFSR taps.
  always_comb begin
    h   = l_q[64] ^ (l_q[3] & l_q[25]) ^ (l_q[46] & l_q[64]) ^ (l_q[25] & n_q[23]);
    out = n_q[1] ^ n_q[4] ^ n_q[10] ^ n_q[15] ^ n_q[21] ^ h;
  end

  // State register: async clear, then load > shift > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q <= '0;
      n_q <= '0;
    end else if (Par_load) begin
      l_q <= Seed[79:0];
      n_q <= Seed[103:80];
    end else if (shift_en) begin
      l_q <= {fb_l, l_q[79:1]};
      n_q <= {fb_n, n_q[23:1]};
    end
  end

  assign out_l = l_q;
  assign out_n = n_q;

endmodule

// File: tb/tb_grain.sv
// Self-checking bench for grain: directed scenarios plus randomized stimulus
// checked against a tap-list reference model.
module tb_grain;

  logic         clk;
  logic         rst;
  logic         shift_en;
  logic         Par_load;
  logic [104:0] Seed;
  logic         out;
  logic [79:0]  out_l;
  logic [23:0]  out_n;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference state
  logic [79:0] ml;
  logic [23:0] mn;

  grain dut (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .Par_load (Par_load),
    .Seed     (Seed),
    .out      (out),
    .out_l    (out_l),
    .out_n    (out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic par_taps_l(input logic [79:0] v);
    int lt[6] = '{0, 13, 23, 38, 51, 62};
    logic r = 1'b0;
    foreach (lt[i]) r = r ^ v[lt[i]];
    return r;
  endfunction

  function automatic logic m_out(input logic [79:0] l, input logic [23:0] n);
    int nt[5] = '{1, 4, 10, 15, 21};
    logic r = 1'b0;
    foreach (nt[i]) r = r ^ n[nt[i]];
    r = r ^ l[64] ^ (l[3] & l[25]) ^ (l[46] & l[64]) ^ (l[25] & n[23]);
    return r;
  endfunction

  task automatic m_step();
    int nt[5] = '{0, 5, 9, 14, 20};
    logic fl, fn;
    fl = par_taps_l(ml);
    fn = ml[0];
    foreach (nt[i]) fn = fn ^ mn[nt[i]];
    fn = fn ^ (mn[3] & mn[7]) ^ (mn[11] & mn[17]) ^ (mn[2] & mn[19] & mn[22]);
    ml = (ml >> 1) | ({79'd0, fl} << 79);
    mn = (mn >> 1) | ({23'd0, fn} << 23);
  endtask

  function automatic logic [104:0] rand_seed();
    logic [104:0] s;
    s = {$urandom, $urandom, $urandom, $urandom};
    return s;
  endfunction

  // Apply inputs, clock one edge, update the model, sample 1 ns later.
  task automatic cycle(input logic pl, input logic se, input logic [104:0] sd);
    Par_load = pl;
    shift_en = se;
    Seed     = sd;
    @(posedge clk);
    if (!rst) begin
      if (pl) begin
        ml = sd[79:0];
        mn = sd[103:80];
      end else if (se) begin
        m_step();
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ml = '0;
    mn = '0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, i[0], rand_seed());
      total++;
      if (out_l !== 80'd0 || out_n !== 24'd0 || out !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: l=%h n=%h out=%b want all zero", i, out_l, out_n, out);
      end
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load();
    cycle(1'b1, 1'b0, 105'h0abcdef123abc12345ab6789cde);
    total++;
    if (out_l !== 80'h123abc12345ab6789cde || out_n !== 24'habcdef || out !== 1'b0) begin
      bad++;
      $display("FAIL load: l=%h n=%h out=%b want l=123abc12345ab6789cde n=abcdef out=0",
               out_l, out_n, out);
    end
  endtask

  task automatic test_first_step();
    cycle(1'b0, 1'b1, rand_seed());
    total++;
    if (out_l !== 80'h891d5e091a2d5b3c4e6f || out_n !== 24'hd5e6f7) begin
      bad++;
      $display("FAIL first_step: l=%h n=%h want l=891d5e091a2d5b3c4e6f n=d5e6f7", out_l, out_n);
    end
    total++;
    if (out !== m_out(ml, mn)) begin
      bad++;
      $display("FAIL first_step_out: got %b want %b", out, m_out(ml, mn));
    end
  endtask

  task automatic test_load_priority();
    logic [104:0] s;
    for (int i = 0; i < 3; i++) begin
      s = rand_seed();
      cycle(1'b1, 1'b1, s);
      total++;
      if (out_l !== s[79:0] || out_n !== s[103:80]) begin
        bad++;
        $display("FAIL load_priority[%0d]: l=%h n=%h want l=%h n=%h",
                 i, out_l, out_n, s[79:0], s[103:80]);
      end
    end
  endtask

  task automatic test_hold_run();
    logic [79:0] hl;
    logic [23:0] hn;
    cycle(1'b1, 1'b0, rand_seed());
    hl = ml;
    hn = mn;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, rand_seed());
      total++;
      if (out_l !== hl || out_n !== hn) begin
        bad++;
        $display("FAIL hold[%0d]: l=%h n=%h want l=%h n=%h", i, out_l, out_n, hl, hn);
      end
    end
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 1'b1, rand_seed());
      total++;
      if (out !== m_out(ml, mn) || out_l !== ml || out_n !== mn) begin
        bad++;
        $display("FAIL run[%0d]: out=%b l=%h n=%h want out=%b l=%h n=%h",
                 i, out, out_l, out_n, m_out(ml, mn), ml, mn);
      end
    end
  endtask

  task automatic test_zero();
    cycle(1'b1, 1'b0, 105'd0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 105'd0);
      total++;
      if (out_l !== 80'd0 || out_n !== 24'd0 || out !== 1'b0) begin
        bad++;
        $display("FAIL zero[%0d]: l=%h n=%h out=%b want all zero", i, out_l, out_n, out);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, rand_seed() | 105'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, rand_seed());
    #2;
    rst = 1'b1;
    #1;
    ml = '0;
    mn = '0;
    total++;
    if (out_l !== 80'd0 || out_n !== 24'd0 || out !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: l=%h n=%h out=%b want all zero before edge", out_l, out_n, out);
    end
    cycle(1'b0, 1'b1, rand_seed());
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, rand_seed());
      total++;
      if (out_l !== 80'd0 || out_n !== 24'd0) begin
        bad++;
        $display("FAIL post_reset[%0d]: l=%h n=%h want zero", i, out_l, out_n);
      end
    end
  endtask

  task automatic test_seed_msb();
    logic [104:0] s;
    s = rand_seed();
    s[104] = 1'b1;
    cycle(1'b1, 1'b0, s);
    total++;
    if (out_l !== s[79:0] || out_n !== s[103:80] || out !== m_out(ml, mn)) begin
      bad++;
      $display("FAIL seed_msb: l=%h n=%h out=%b want l=%h n=%h out=%b",
               out_l, out_n, out, s[79:0], s[103:80], m_out(ml, mn));
    end
  endtask

  task automatic test_random();
    logic pl, se;
    for (int i = 0; i < 300; i++) begin
      pl = ($urandom_range(0, 15) == 0);
      se = $urandom_range(0, 3) != 0;
      cycle(pl, se, rand_seed());
      total++;
      if (out !== m_out(ml, mn) || out_l !== ml || out_n !== mn) begin
        bad++;
        $display("FAIL random[%0d]: out=%b l=%h n=%h want out=%b l=%h n=%h",
                 i, out, out_l, out_n, m_out(ml, mn), ml, mn);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    shift_en = 1'b0;
    Par_load = 1'b0;
    Seed     = '0;
    ml       = '0;
    mn       = '0;
    #3;
    test_reset();
    test_load();
    test_first_step();
    test_load_priority();
    test_hold_run();
    test_zero();
    test_async_reset();
    test_seed_msb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grain.md
Name: grain

Overview:
- Grain-style keystream generator: an 80-bit LFSR coupled to a 24-bit NLFSR, with a nonlinear output filter producing one keystream bit per enabled clock.
- Both registers are loaded in parallel from a 105-bit seed, then stepped under shift_en.
- Full internal state is exported for debug and verification.
- Sits as a leaf in the stream-cipher datapath; recommended split is LFSR, NLFSR and filter sub-blocks.

Parameters:
- none (widths fixed: LFSR 80, NLFSR 24, seed 105)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- shift_en  input  1  advance both registers one step this cycle
- Par_load  input  1  parallel-load both registers from Seed this cycle
- Seed  input  105  load value: Seed[79:0] to LFSR, Seed[103:80] to NLFSR, Seed[104] ignored
- out  output  1  keystream bit (combinational from current state)
- out_l  output  80  current LFSR state L[79:0]
- out_n  output  24  current NLFSR state N[23:0]

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - rst=1 immediately clears L and N to 0, independent of clk.
  - out_l=0, out_n=0 and out=0 while rst is asserted.
  - rst has priority over every other input.
- Priority on each rising edge (rst low): Par_load > shift_en > hold.
  - Par_load=1: L<=Seed[79:0], N<=Seed[103:80], no shift, even if shift_en=1.
  - shift_en=1 (Par_load=0): one step.
  - Neither asserted: state holds.
- LFSR step (shift right, new bit enters MSB):
  - fb_l = L[0]^L[13]^L[23]^L[38]^L[51]^L[62]
  - L <= {fb_l, L[79:1]}
- NLFSR step:
  - fb_n = L[0]^N[0]^N[5]^N[9]^N[14]^N[20]^(N[3]&N[7])^(N[11]&N[17])^(N[2]&N[19]&N[22])
  - N <= {fb_n, N[23:1]}
- fb_l and fb_n are both computed from pre-step state; L and N update on the same edge.
- Output filter:
  - h = L[64]^(L[3]&L[25])^(L[46]&L[64])^(L[25]&N[23])
  - out = N[1]^N[4]^N[10]^N[15]^N[21]^h
- Timing and latency:
  - out, out_l and out_n are purely combinational from the registers, with no extra pipeline stage.
  - out reflects the state after the most recent edge.
  - Load-to-first-valid-out latency is 0 cycles after the load edge; each shift edge yields the next keystream bit.
- All-zero state is a fixed point: zero state stays zero under shifting and out=0. No lockout protection is provided.
- Reset mid-operation: state clears at once. After rst deasserts, the registers stay zero until a Par_load.
- Seed changes while neither Par_load nor rst is asserted have no effect.
- Seed[104] has no effect on any output under any condition.

Test Plan:
- Reset: rst=1 with arbitrary Seed, Par_load=1, shift_en=1 toggling over several edges -> out_l=0, out_n=0, out=0 throughout.
- Load: rst=0, Seed=105'h0abcdef123abc12345ab6789cde, Par_load=1 for one edge -> out_l=80'h123abc12345ab6789cde, out_n=24'habcdef, out=0.
- First step from the loaded state, shift_en=1 for one edge -> out_l=80'h891d5e091a2d5b3c4e6f, out_n=24'hd5e6f7.
- Load priority: Par_load=1 and shift_en=1 on the same edge -> loaded seed values exactly, no shift applied.
- Hold, then run:
  - shift_en=0 and Par_load=0 for 5 edges -> state unchanged.
  - Then 31 shift edges -> out sequence and state match a bit-exact software model of the equations above.
- Zero fixed point and mid-run reset:
  - Load Seed=0 and shift 20 cycles -> state stays 0, out=0.
  - Assert rst asynchronously, between clock edges, mid-run -> state clears without waiting for a clock edge.
